// File: rtl/shared_adder_arb.sv
// Round-robin arbiter sharing one N-bit adder between two requesters; 1-cycle latency, result held while res_ready=0.
// Define SHARED_ADDER_OVF_CNT_EN to add the saturating carry-out counter (ovf_count).
module shared_adder_arb #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [N:0]   res_sum,
   output logic         res_id,
   output logic         busy
`ifdef SHARED_ADDER_OVF_CNT_EN
   ,
   output logic [7:0]   ovf_count
`endif
);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t       state_q;
   logic         last_grant_q;
   logic [N:0]   res_sum_q;
   logic         res_id_q;

   logic         accept_win;
   logic         win0;
   logic         win1;
   logic         xfer;
   logic         sel;
   logic [N-1:0] op_a;
   logic [N-1:0] op_b;
   logic [N:0]   res_sum_d;

   // Readies are forced low in reset so no requester sees a phantom handshake.
   assign accept_win = rst_n && ((state_q == IDLE) || res_ready);
   assign win0       = req0_valid && (!req1_valid || last_grant_q);
   assign win1       = req1_valid && (!req0_valid || !last_grant_q);
   assign req0_ready = accept_win && win0;
   assign req1_ready = accept_win && win1;
   assign xfer       = req0_ready || req1_ready;
   assign sel        = req1_ready;

   assign op_a       = sel ? req1_a : req0_a;
   assign op_b       = sel ? req1_b : req0_b;
   assign res_sum_d  = {1'b0, op_a} + {1'b0, op_b};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         res_sum_q    <= '0;
         res_id_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (xfer) begin
                  state_q      <= HOLD;
                  res_sum_q    <= res_sum_d;
                  res_id_q     <= sel;
                  last_grant_q <= sel;
               end
            end
            HOLD: begin
               if (xfer) begin
                  res_sum_q    <= res_sum_d;
                  res_id_q     <= sel;
                  last_grant_q <= sel;
               end else if (res_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign res_valid = (state_q == HOLD);
   assign busy      = (state_q == HOLD);
   assign res_sum   = res_sum_q;
   assign res_id    = res_id_q;

`ifdef SHARED_ADDER_OVF_CNT_EN
   logic [7:0] ovf_count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_count_q <= 8'd0;
      end else if (xfer && res_sum_d[N] && (ovf_count_q != 8'hFF)) begin
         ovf_count_q <= ovf_count_q + 8'd1;
      end
   end

   assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_shared_adder_arb.sv
// Bench for shared_adder_arb: round-robin reference model feeding a result scoreboard.
module tb_shared_adder_arb;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         res_valid, res_ready, res_id, busy;
   logic [N:0]   res_sum;
`ifdef SHARED_ADDER_OVF_CNT_EN
   logic [7:0]   ovf_count;
`endif

   shared_adder_arb #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_sum    (res_sum),
      .res_id     (res_id),
      .busy       (busy)
`ifdef SHARED_ADDER_OVF_CNT_EN
      ,
      .ovf_count  (ovf_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       id;
      logic [N:0] sum;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b0;

   // Stimulus intent (what requesters present this cycle)
   bit           rst_v = 1'b0;
   bit           rr    = 1'b0;
   bit           v0 = 1'b0, v1 = 1'b0;
   logic [N-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   bit           tx0, tx1;

   // Reference model state
   bit           m_last = 1'b1;
   bit           m_pend = 1'b0;
   int           m_ovf  = 0;

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive, predict the grant from the round-robin rule, then record the transfer.
   task automatic step();
      bit win0, win1, open, e0, e1;
      int s;
      @(negedge clk);
      rst_n      = rst_v;
      res_ready  = rr;
      req0_valid = v0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_a = a1; req1_b = b1;
      #1;
      win0 = v0 && (!v1 || m_last == 1'b1);
      win1 = v1 && (!v0 || m_last == 1'b0);
      open = rst_v && (!m_pend || rr);
      e0   = open && win0;
      e1   = open && win1;
      chk(req0_ready === e0, "req0_ready", int'(req0_ready), int'(e0));
      chk(req1_ready === e1, "req1_ready", int'(req1_ready), int'(e1));
      @(posedge clk);
      if (!rst_v) begin
         exp_q.delete();
         m_last = 1'b1;
         m_pend = 1'b0;
         m_ovf  = 0;
      end else if (e0 || e1) begin
         s = e1 ? (int'(a1) + int'(b1)) : (int'(a0) + int'(b0));
         exp_q.push_back('{id: e1, sum: s[N:0]});
         m_last = e1;
         m_pend = 1'b1;
         if (s >= (1 << N) && m_ovf < 255) m_ovf++;
      end else if (rr) begin
         m_pend = 1'b0;
      end
      tx0 = e0;
      tx1 = e1;
   endtask

   // Scoreboard monitor: compare whatever result the DUT presents, retire it on handshake.
   always @(negedge clk) begin
      #2;
      if (mon_en) begin
         chk(res_valid === (exp_q.size() != 0), "res_valid", int'(res_valid), int'(exp_q.size() != 0));
         chk(busy === res_valid, "busy", int'(busy), int'(res_valid));
         if (res_valid === 1'b1 && exp_q.size() != 0) begin
            chk(res_sum === exp_q[0].sum, "res_sum", int'(res_sum), int'(exp_q[0].sum));
            chk(res_id === exp_q[0].id, "res_id", int'(res_id), int'(exp_q[0].id));
            if (res_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic refresh_random();
      if (tx0 || !v0) begin
         v0 = ($urandom_range(0, 3) != 0);
         a0 = N'($urandom()); b0 = N'($urandom());
      end
      if (tx1 || !v1) begin
         v1 = ($urandom_range(0, 3) != 0);
         a1 = N'($urandom()); b1 = N'($urandom());
      end
      rr = ($urandom_range(0, 3) != 0);
   endtask

   initial begin
      rst_n = 1'b0; res_ready = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

      // Reset with requests pending: readies must stay low
      rst_v = 1'b0; v0 = 1'b1; v1 = 1'b1; rr = 1'b1;
      step(); step();
      #1;
      chk(res_valid === 1'b0, "rst_res_valid", int'(res_valid), 0);
      chk(res_sum === '0, "rst_res_sum", int'(res_sum), 0);
      chk(res_id === 1'b0, "rst_res_id", int'(res_id), 0);
      chk(busy === 1'b0, "rst_busy", int'(busy), 0);
      mon_en = 1'b1;

      // Single request with carry
      rst_v = 1'b1; v1 = 1'b0; v0 = 1'b1; a0 = 4'hF; b0 = 4'h1; rr = 1'b1;
      step();
      v0 = 1'b0;
      step(); step();

      // Contention: both valid continuously, distinct operands per grant
      v0 = 1'b1; v1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a0 = N'(i); b0 = 4'h3; a1 = N'(i + 8); b1 = 4'h9;
         step();
      end

      // Backpressure: hold result for 3 cycles, then release
      rr = 1'b0;
      for (int i = 0; i < 3; i++) step();
      rr = 1'b1; a0 = 4'h7; b0 = 4'h6; a1 = 4'hE; b1 = 4'hE;
      step();
      v0 = 1'b0; v1 = 1'b0;
      step(); step();

      // Reset while a result is held, then a tie goes to requester 0
      v0 = 1'b1; a0 = 4'h5; b0 = 4'h5; rr = 1'b0;
      step();
      v0 = 1'b0;
      step();
      rst_v = 1'b0;
      step();
      rst_v = 1'b1; v0 = 1'b1; v1 = 1'b1; rr = 1'b1; a1 = 4'h2; b1 = 4'h2;
      step();
      chk(tx0 === 1'b1 && req0_ready === 1'b1, "tie_after_reset", int'(req0_ready), 1);
      v0 = 1'b0; v1 = 1'b0;
      step(); step();

      // Randomized traffic with random consumer backpressure
      for (int i = 0; i < 2000; i++) begin
         refresh_random();
         step();
      end

`ifdef SHARED_ADDER_OVF_CNT_EN
      rst_v = 1'b0; v0 = 1'b0; v1 = 1'b0;
      step();
      rst_v = 1'b1; rr = 1'b1; v0 = 1'b1; a0 = 4'h8; b0 = 4'h8;
      for (int i = 0; i < 3; i++) step();
      #1;
      chk(ovf_count === 8'(m_ovf) && m_ovf == 3, "ovf_count_3", int'(ovf_count), 3);
      for (int i = 0; i < 300; i++) step();
      #1;
      chk(ovf_count === 8'(m_ovf) && m_ovf == 255, "ovf_count_sat", int'(ovf_count), 255);
`endif

      // Drain
      v0 = 1'b0; v1 = 1'b0; rr = 1'b1;
      for (int i = 0; i < 4; i++) step();
      @(negedge clk);
      #3;
      chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/shared_adder_arb.md
SHARED_ADDER_ARB -- requirements
Module: shared_adder_arb

Interface
REQ-001 Parameter: N, default 4, operand width in bits (N >= 1).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operand pair pending.
REQ-005 req0_ready  output  1  requester 0 pair accepted this cycle when req0_valid also high.
REQ-006 req0_a, req0_b  input  N each  requester 0 operands.
REQ-007 req1_valid, req1_ready, req1_a, req1_b  as REQ-004..006 for requester 1.
REQ-008 res_valid  output  1  res_sum/res_id hold a valid result.
REQ-009 res_ready  input  1  consumer accepts the result this cycle.
REQ-010 res_sum  output  N+1  unsigned sum, MSB = carry-out.
REQ-011 res_id  output  1  index of the requester that owns res_sum.
REQ-012 busy  output  1  high whenever res_valid is high.
REQ-013 ovf_count  output  8  results with carry-out set; present only under the Configuration macro.

Function
REQ-014 The block shall contain one N-bit unsigned adder, time-shared between the two requesters; sum = zero-extended a + b, N+1 bits, never truncated.
REQ-015 FSM states: IDLE (res_valid=0) and HOLD (res_valid=1); busy = (state == HOLD).
REQ-016 Accept window: the block accepts a request when state==IDLE, or when state==HOLD and res_ready==1.
REQ-017 Arbitration is round-robin on last_grant: only one valid -> that requester wins; both valid -> the requester != last_grant wins.
REQ-018 reqX_ready shall be high only for the winner, only inside the accept window, and is combinational from state, res_ready, reqX_valid and last_grant.
REQ-019 A transfer is reqX_valid && reqX_ready; at most one transfer per cycle.
REQ-020 On a transfer at edge k, res_sum, res_id, last_grant and state=HOLD are registered at edge k, so latency is 1 cycle.
REQ-021 In HOLD with res_ready=0, res_sum and res_id shall be held unchanged, and both readies are 0.
REQ-022 In HOLD with res_ready=1 and no request, next state is IDLE and res_valid falls at the next edge.
REQ-023 In HOLD with res_ready=1 and a request, the new result replaces the old one at the next edge; res_valid stays high, giving a sustained throughput of 1 result/cycle.
REQ-024 Requesters shall hold valid and operands stable until transfer; the block does not sample operands outside a transfer.
REQ-025 res_sum and res_id shall change only on a transfer or on reset.

Reset
REQ-026 With rst_n=0 at an edge: state=IDLE, res_valid=0, res_sum=0, res_id=0, last_grant=1 (requester 0 wins the first tie), ovf_count=0.
REQ-027 Reset mid-HOLD shall discard the pending result without handshake.
REQ-028 While rst_n=0, both readies shall be 0.

Configuration
REQ-029 Macro SHARED_ADDER_OVF_CNT_EN: when defined, ovf_count increments on each transfer whose sum MSB is 1, and saturates at 255.
REQ-030 Without SHARED_ADDER_OVF_CNT_EN: no ovf_count port and no counter logic; all other behaviour is identical.

Verification
REQ-031 Reset: rst_n=0 for 2 cycles, then release -> res_valid=0, res_sum=0, res_id=0, busy=0, both readies 0 during reset.
REQ-032 Single request: N=4, req0 a=4'hF b=4'h1, res_ready=1 -> req0_ready=1 same cycle; next cycle res_valid=1, res_sum=5'h10, res_id=0; then IDLE.
REQ-033 Contention: both valid continuously, res_ready=1 -> grant order 0,1,0,1; one result per cycle; res_id alternates.
REQ-034 Backpressure: result present, res_ready=0 for 3 cycles -> res_sum/res_id stable; req0_ready=req1_ready=0; release -> new result in the following cycle.
REQ-035 Reset mid-HOLD: res_valid=1, rst_n=0 one cycle -> res_valid=0; next tie is won by requester 0.
REQ-036 Macro defined: 3 transfers with carry (a=4'h8, b=4'h8) -> ovf_count=3; 300 carry transfers -> ovf_count=255.
